// File: rtl/lowrisc_chip_top.sv
// lowrisc_chip_top: UART byte echo (rxd -> txd) for the bring-up image.
// Define SPI_BRIDGE_EN to pass each byte through one SPI mode-0 transfer before TX.
module lowrisc_chip_top #(
    parameter int CLK_PER_BIT = 1736,
    parameter int SPI_DIV     = 4
) (
    input  logic clk_p,
    input  logic clk_n,
    input  logic rst_top,
    input  logic rxd,
    output logic txd,
    output logic spi_cs,
    output logic spi_sclk,
    output logic spi_mosi,
    input  logic spi_miso
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] C_FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic r_rst_meta, r_rst;
    logic r_rx_s1, r_rx_s2, r_rx_s3, r_rx_vld;
    logic [1:0] r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0] r_rx_bit;
    logic [7:0] r_rx_sh;
    logic r_hold_v;
    logic [7:0] r_hold_d;
    logic w_hold_take, w_src_v, w_tx_take, w_unused;
    logic [7:0] w_src_d;
    logic [1:0] r_tx_st;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0] r_tx_bit;
    logic [7:0] r_tx_sh;
    logic r_txd;

    // Reset asserts immediately and releases two edges after rst_top falls.
    always_ff @(posedge clk_p or posedge rst_top) begin
        if (rst_top) {r_rst_meta, r_rst} <= 2'b11;
        else {r_rst_meta, r_rst} <= {1'b0, r_rst_meta};
    end

    always_ff @(posedge clk_p or posedge r_rst) begin
        if (r_rst) begin
            {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
            r_rx_st <= S_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh <= '0;
            r_rx_vld <= 1'b0;
        end else begin
            {r_rx_s1, r_rx_s2, r_rx_s3} <= {rxd, r_rx_s1, r_rx_s2};
            r_rx_vld <= 1'b0;
            r_rx_cnt <= r_rx_cnt + 1'b1;
            case (r_rx_st)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_s3 && !r_rx_s2) r_rx_st <= S_START;
                end
                S_START: if (r_rx_cnt == C_HALF) begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (r_rx_cnt == C_FULL) begin
                    r_rx_cnt <= '0;
                    r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 1'b1;
                    if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
                end
                default: if (r_rx_cnt == C_FULL) begin
                    r_rx_vld <= r_rx_s2;
                    r_rx_st <= S_IDLE;
                end
            endcase
        end
    end

    // A byte landing while the register is full (or being drained) is lost.
    always_ff @(posedge clk_p or posedge r_rst) begin
        if (r_rst) begin
            r_hold_v <= 1'b0;
            r_hold_d <= '0;
        end else if (w_hold_take) begin
            r_hold_v <= 1'b0;
        end else if (r_rx_vld && !r_hold_v) begin
            r_hold_v <= 1'b1;
            r_hold_d <= r_rx_sh;
        end
    end

`ifdef SPI_BRIDGE_EN
    localparam int DW = $clog2(SPI_DIV + 1);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_XFER = 2'd1;
    localparam logic [1:0] P_GAP  = 2'd2;
    logic [1:0] r_spi_st;
    logic [DW-1:0] r_spi_cnt;
    logic [4:0] r_spi_ph;
    logic [7:0] r_spi_sh;
    logic r_spi_fin, r_so_v, r_cs, r_sclk, r_mosi;
    logic [4:0] w_np;
    logic w_ph_end;

    assign w_np = r_spi_ph + 5'd1;
    assign w_ph_end = r_spi_cnt == DW'(SPI_DIV - 1);
    assign w_hold_take = r_spi_st == P_IDLE && r_hold_v && !r_so_v && !r_spi_fin;
    assign w_src_v = r_so_v;
    assign w_src_d = r_spi_sh;
    assign spi_cs = r_cs;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign w_unused = clk_n;

    // 18 phases of SPI_DIV cycles: lead-in, 8 x (low, high), tail; even phases are sclk high.
    always_ff @(posedge clk_p or posedge r_rst) begin
        if (r_rst) begin
            r_spi_st <= P_IDLE;
            r_spi_cnt <= '0;
            r_spi_ph <= '0;
            r_spi_sh <= '0;
            r_spi_fin <= 1'b0;
            r_so_v <= 1'b0;
            r_cs <= 1'b1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
        end else begin
            r_spi_fin <= 1'b0;
            r_spi_cnt <= w_ph_end ? '0 : r_spi_cnt + 1'b1;
            if (r_spi_fin) r_so_v <= 1'b1;
            else if (w_tx_take) r_so_v <= 1'b0;
            case (r_spi_st)
                P_IDLE: begin
                    r_spi_cnt <= '0;
                    if (w_hold_take) begin
                        r_spi_st <= P_XFER;
                        r_spi_ph <= '0;
                        r_spi_sh <= r_hold_d;
                        r_cs <= 1'b0;
                        r_mosi <= r_hold_d[7];
                    end
                end
                P_XFER: if (w_ph_end) begin
                    r_spi_ph <= w_np;
                    r_sclk <= !w_np[0] && w_np != 5'd18;
                    if (!w_np[0] && w_np != 5'd18) r_spi_sh <= {r_spi_sh[6:0], spi_miso};
                    if (w_np[0] && w_np > 5'd2 && w_np < 5'd17) r_mosi <= r_spi_sh[7];
                    if (w_np == 5'd18) begin
                        r_cs <= 1'b1;
                        r_mosi <= 1'b0;
                        r_spi_fin <= 1'b1;
                        r_spi_st <= P_GAP;
                    end
                end
                default: if (w_ph_end) r_spi_st <= P_IDLE;
            endcase
        end
    end
`else
    assign w_hold_take = w_tx_take;
    assign w_src_v = r_hold_v;
    assign w_src_d = r_hold_d;
    assign spi_cs = 1'b1;
    assign spi_sclk = 1'b0;
    assign spi_mosi = 1'b0;
    assign w_unused = clk_n ^ spi_miso;
`endif

    assign w_tx_take = r_tx_st == S_IDLE && w_src_v;
    assign txd = r_txd;

    always_ff @(posedge clk_p or posedge r_rst) begin
        if (r_rst) begin
            r_tx_st <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh <= '0;
            r_txd <= 1'b1;
        end else begin
            r_tx_cnt <= (r_tx_st == S_IDLE || r_tx_cnt == C_FULL) ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_st)
                S_IDLE: if (w_src_v) begin
                    r_tx_st <= S_START;
                    r_txd <= 1'b0;
                    r_tx_sh <= w_src_d;
                end
                S_START: if (r_tx_cnt == C_FULL) begin
                    r_tx_st <= S_DATA;
                    r_txd <= r_tx_sh[0];
                    r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                    r_tx_bit <= '0;
                end
                S_DATA: if (r_tx_cnt == C_FULL) begin
                    r_tx_bit <= r_tx_bit + 1'b1;
                    r_txd <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[0];
                    r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                    if (r_tx_bit == 3'd7) r_tx_st <= S_STOP;
                end
                default: if (r_tx_cnt == C_FULL) r_tx_st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lowrisc_chip_top.sv
// tb_lowrisc_chip_top: random UART bytes against a byte-level echo model.
`timescale 1ns/100ps
module tb_lowrisc_chip_top;
    localparam int C = 16;
    localparam int DIV = 2;
`ifdef SPI_BRIDGE_EN
    localparam int BRIDGE = 1;
`else
    localparam int BRIDGE = 0;
`endif
    // Nominal: mid-stop sample + 2 sync + 2 cycles, plus the SPI transfer when bridged.
    localparam int LAT_LO = C / 2 + 3 + BRIDGE * (18 * DIV + 2);

    logic clk_p = 1'b0, rst_top = 1'b0, rxd = 1'b1, miso_tie = 1'b0;
    logic clk_n, txd, spi_cs, spi_sclk, spi_mosi, spi_miso;
    int n_vec = 0, n_err = 0, cyc = 0, epoch = 0, n_falls = 0;
    int t_stop, mon_tf, mon_ep, m_n0, m_k;
    logic [7:0] mon_b, m_b;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int fall_q[$];

    lowrisc_chip_top #(.CLK_PER_BIT(C), .SPI_DIV(DIV)) dut (
        .clk_p(clk_p), .clk_n(clk_n), .rst_top(rst_top), .rxd(rxd), .txd(txd),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #2.5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;
    assign spi_miso = miso_tie | spi_mosi;
    always @(posedge clk_p) cyc <= cyc + 1;
    always @(posedge rst_top) epoch <= epoch + 1;
    always @(negedge txd) n_falls <= n_falls + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] b);
        return (BRIDGE != 0 && miso_tie) ? 8'hFF : b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_p);
        rxd = 1'b0;
        repeat (C) @(negedge clk_p);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk_p);
        end
        rxd = stop_bit;
        t_stop = cyc;
        repeat (C) @(negedge clk_p);
        rxd = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk_p);
            k++;
        end
        check("rx_count", got_q.size(), n);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int lat;
        wait_got(1, 24 * C);
        if (got_q.size() == 0 || fall_q.size() == 0) return;
        check(tag, got_q.pop_front(), exp);
        lat = fall_q.pop_front() - t_stop;
        check($sformatf("%s_lat=%0d(window %0d..%0d)", tag, lat, LAT_LO, LAT_LO + 3),
              lat >= LAT_LO && lat <= LAT_LO + 3, 1);
    endtask

    // TX frame decoder; frames cut by a reset are discarded.
    initial begin
        forever begin
            @(negedge txd);
            #1;
            mon_ep = epoch;
            mon_tf = cyc;
            repeat (C / 2) @(negedge clk_p);
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk_p);
                mon_b[i] = txd;
            end
            repeat (C) @(negedge clk_p);
            if (mon_ep == epoch) begin
                check("tx_stop", txd, 1);
                got_q.push_back(mon_b);
                fall_q.push_back(mon_tf);
            end
        end
    end

`ifdef SPI_BRIDGE_EN
    int spi_t0, spi_t1, spi_pulses;
    logic [7:0] spi_mo;
    initial begin
        forever begin
            @(negedge spi_cs);
            #1;
            spi_t0 = cyc;
            spi_pulses = 0;
            spi_mo = '0;
            while (spi_cs === 1'b0) begin
                @(posedge spi_sclk or posedge spi_cs);
                if (spi_cs === 1'b0) begin
                    spi_pulses++;
                    spi_mo = {spi_mo[6:0], spi_mosi};
                end
            end
            #1;
            spi_t1 = cyc;
        end
    end
`else
    int n_sclk = 0;
    always @(posedge spi_sclk) n_sclk <= n_sclk + 1;
`endif

    initial begin
        #3 rst_top = 1'b1;
        #47;
        check("rst_txd", txd, 1);
        check("rst_cs", spi_cs, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        #83 rst_top = 1'b0;
        repeat (30) @(negedge clk_p);
        check("post_txd", txd, 1);
        check("post_cs", spi_cs, 1);
        check("post_sclk", spi_sclk, 0);
        check("post_no_tx", n_falls, 0);

        got_q.delete();
        fall_q.delete();
        send_byte(8'hA5, 1'b1);
        expect_byte("echo_a5", model(8'hA5));

        got_q.delete();
        fall_q.delete();
        for (int i = 0; i < 8; i++) begin
            m_b = 8'($urandom);
            exp_q.push_back(model(m_b));
            send_byte(m_b, 1'b1);
        end
        wait_got(8, 30 * C);
        while (got_q.size() > 0 && exp_q.size() > 0) check("rand_echo", got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();

        m_n0 = n_falls;
        @(negedge clk_p);
        rxd = 1'b0;
        repeat (C / 4) @(negedge clk_p);
        rxd = 1'b1;
        repeat (12 * C) @(negedge clk_p);
        check("false_start", n_falls - m_n0, 0);
        m_n0 = n_falls;
        send_byte(8'h81, 1'b0);
        repeat (12 * C) @(negedge clk_p);
        check("frame_err", n_falls - m_n0, 0);

`ifdef SPI_BRIDGE_EN
        got_q.delete();
        fall_q.delete();
        send_byte(8'h3C, 1'b1);
        expect_byte("spi_loop", 8'h3C);
        check("spi_mosi", spi_mo, 8'h3C);
        check("spi_pulses", spi_pulses, 8);
        check("spi_cs_len", spi_t1 - spi_t0, 18 * DIV);
        check("spi_tx_gap", mon_tf - spi_t1, 2);
        miso_tie = 1'b1;
        got_q.delete();
        fall_q.delete();
        send_byte(8'h00, 1'b1);
        expect_byte("spi_sub", model(8'h00));
        miso_tie = 1'b0;
`endif

        got_q.delete();
        fall_q.delete();
        m_n0 = n_falls;
        send_byte(8'hC3, 1'b1);
        m_k = 0;
        while (n_falls == m_n0 && m_k < 30 * C) begin
            @(negedge clk_p);
            m_k++;
        end
        check("mid_fall_seen", n_falls - m_n0, 1);
        repeat (4 * C + C / 2) @(negedge clk_p);
        check("mid_bit3_low", txd, 0);
        #1 rst_top = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_cs", spi_cs, 1);
        check("mid_rst_sclk", spi_sclk, 0);
        repeat (3) @(negedge clk_p);
        rst_top = 1'b0;
        repeat (12 * C) @(negedge clk_p);
        check("mid_discard", got_q.size(), 0);
        got_q.delete();
        fall_q.delete();
        send_byte(8'h5A, 1'b1);
        expect_byte("after_rst", model(8'h5A));

`ifndef SPI_BRIDGE_EN
        check("nb_cs", spi_cs, 1);
        check("nb_mosi", spi_mosi, 0);
        check("nb_sclk_edges", n_sclk, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
